// File: rtl/alu_pkg.sv
// Shared ALU opcode and RISC-V major-opcode constants for the ID/EX control stage and the ALU.
package alu_pkg;
    localparam int DATA_W = 64;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
endpackage

// File: rtl/alu_dec.sv
// Combinational ALU-control decode: selects ALU operands and opcode from the raw instruction.
// Optional illegal-instruction flag under IDEX_ILLEGAL_DETECT_EN.
module alu_dec
    import alu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
`ifdef IDEX_ILLEGAL_DETECT_EN
    output logic              illegal,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              is_branch,
    output logic [2:0]        br_funct3
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_ADD;
        is_branch = 1'b0;
        br_funct3 = 3'b000;
        case (opcode)
            OPC_OP: begin
                alu_op = {instr[30], funct3};
                alu_a  = rs1_data;
                alu_b  = rs2_data;
            end
            OPC_OP_IMM: begin
                // Only SRAI carries instr[30] into the opcode; for other I-ops it is immediate bits.
                alu_op = {(funct3 == 3'b101) & instr[30], funct3};
                alu_a  = rs1_data;
                alu_b  = imm;
            end
            OPC_LOAD, OPC_STORE: begin
                alu_a = rs1_data;
                alu_b = imm;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                br_funct3 = funct3;
                alu_a     = rs1_data;
                alu_b     = rs2_data;
                case (funct3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_SUB;
                endcase
            end
            OPC_LUI:   alu_b = imm;
            OPC_AUIPC: begin
                alu_a = pc;
                alu_b = imm;
            end
            OPC_JAL, OPC_JALR: begin
                alu_a = pc;
                alu_b = DATA_W'(4);
            end
            default: ;
        endcase
    end

`ifdef IDEX_ILLEGAL_DETECT_EN
    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OPC_OP:
                illegal = !((instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000));
            OPC_OP_IMM:
                if ((funct3 == 3'b001) || (funct3 == 3'b101))
                    illegal = !((instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000));
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: ;
            default: illegal = 1'b1;
        endcase
    end
`endif
endmodule

// File: rtl/idex_alu_ctrl.sv
// ID/EX handshake register for ALU control; decode lives in alu_dec.
// Optional `illegal` output enabled by IDEX_ILLEGAL_DETECT_EN.
module idex_alu_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef IDEX_ILLEGAL_DETECT_EN
    output logic              illegal,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              is_branch,
    output logic [2:0]        br_funct3
);
    logic [DATA_W-1:0] dec_a, dec_b;
    logic [3:0]        dec_op;
    logic              dec_br;
    logic [2:0]        dec_f3;

    logic              vld_p1;
    logic [DATA_W-1:0] alu_a_p1, alu_b_p1;
    logic [3:0]        alu_op_p1;
    logic              br_p1;
    logic [2:0]        f3_p1;
`ifdef IDEX_ILLEGAL_DETECT_EN
    logic              dec_ill;
    logic              ill_p1;
`endif

    alu_dec #(.DATA_W(DATA_W)) u_dec (
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
`ifdef IDEX_ILLEGAL_DETECT_EN
        .illegal   (dec_ill),
`endif
        .alu_a     (dec_a),
        .alu_b     (dec_b),
        .alu_op    (dec_op),
        .is_branch (dec_br),
        .br_funct3 (dec_f3)
    );

    assign in_ready = !vld_p1 || out_ready;

    // ID -> EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            alu_a_p1  <= '0;
            alu_b_p1  <= '0;
            alu_op_p1 <= ALU_ADD;
            br_p1     <= 1'b0;
            f3_p1     <= 3'b000;
`ifdef IDEX_ILLEGAL_DETECT_EN
            ill_p1    <= 1'b0;
`endif
        end else if (flush) begin
            // Kill only the control bits; operand registers keep their last contents.
            vld_p1 <= 1'b0;
            br_p1  <= 1'b0;
        end else if (in_valid && in_ready) begin
            vld_p1    <= 1'b1;
            alu_a_p1  <= dec_a;
            alu_b_p1  <= dec_b;
            alu_op_p1 <= dec_op;
            br_p1     <= dec_br;
            f3_p1     <= dec_f3;
`ifdef IDEX_ILLEGAL_DETECT_EN
            ill_p1    <= dec_ill;
`endif
        end else if (in_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign alu_a     = alu_a_p1;
    assign alu_b     = alu_b_p1;
    assign alu_op    = alu_op_p1;
    assign is_branch = br_p1;
    assign br_funct3 = f3_p1;
`ifdef IDEX_ILLEGAL_DETECT_EN
    assign illegal   = ill_p1;
`endif
endmodule

// File: tb/tb_idex_alu_ctrl.sv
// Self-checking bench for idex_alu_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_idex_alu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0, rs1_data = '0, rs2_data = '0, imm = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        is_branch;
    logic [2:0]  br_funct3;
`ifdef IDEX_ILLEGAL_DETECT_EN
    logic        illegal;
`endif

    int checks = 0;
    int errs   = 0;

    idex_alu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef IDEX_ILLEGAL_DETECT_EN
        .illegal   (illegal),
`endif
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .is_branch (is_branch),
        .br_funct3 (br_funct3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        br;
        logic [2:0]  f3;
        logic        ill;
    } dec_t;

    // Reference decode written directly from the instruction-class table.
    function automatic dec_t ref_dec(input logic [31:0] i, input logic [63:0] p, r1, r2, im);
        dec_t r;
        logic [2:0] f3;
        f3 = i[14:12];
        r = '0;
        case (i[6:0])
            7'h33: begin
                r.op = {i[30], f3}; r.a = r1; r.b = r2;
                r.ill = !(i[31:25] == 7'h00 || i[31:25] == 7'h20);
            end
            7'h13: begin
                r.op = (f3 == 3'd5) ? {i[30], f3} : {1'b0, f3}; r.a = r1; r.b = im;
                if (f3 == 3'd1 || f3 == 3'd5) r.ill = !(i[31:26] == 6'h00 || i[31:26] == 6'h10);
            end
            7'h03, 7'h23: begin r.a = r1; r.b = im; end
            7'h63: begin
                r.br = 1'b1; r.f3 = f3; r.a = r1; r.b = r2;
                case (f3)
                    3'd4, 3'd5: r.op = 4'b0010;
                    3'd6, 3'd7: r.op = 4'b0011;
                    default:    r.op = 4'b1000;
                endcase
            end
            7'h37: r.b = im;
            7'h17: begin r.a = p; r.b = im; end
            7'h6F, 7'h67: begin r.a = p; r.b = 64'd4; end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Model state: what the EX-facing word must be.
    logic m_vld = 1'b0;
    dec_t m_w = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= 1'b0;
            m_w   <= '0;
        end else if (flush) begin
            m_vld  <= 1'b0;
            m_w.br <= 1'b0;
        end else if (in_valid && (!m_vld || out_ready)) begin
            m_vld <= 1'b1;
            m_w   <= ref_dec(instr, pc, rs1_data, rs2_data, imm);
        end else if (!m_vld || out_ready) begin
            m_vld <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_is_branch", {63'd0, is_branch}, 64'd0);
            chk("rst_alu_op", {60'd0, alu_op}, 64'd0);
            chk("rst_alu_a", alu_a, 64'd0);
            chk("rst_alu_b", alu_b, 64'd0);
            chk("rst_br_funct3", {61'd0, br_funct3}, 64'd0);
`ifdef IDEX_ILLEGAL_DETECT_EN
            chk("rst_illegal", {63'd0, illegal}, 64'd0);
`endif
        end else begin
            chk("m_in_ready", {63'd0, in_ready}, {63'd0, (!m_vld || out_ready)});
            chk("m_out_valid", {63'd0, out_valid}, {63'd0, m_vld});
            chk("m_is_branch", {63'd0, is_branch}, {63'd0, m_w.br});
            if (m_vld) begin
                chk("m_alu_op", {60'd0, alu_op}, {60'd0, m_w.op});
                chk("m_alu_a", alu_a, m_w.a);
                chk("m_alu_b", alu_b, m_w.b);
                chk("m_br_funct3", {61'd0, br_funct3}, {61'd0, m_w.f3});
`ifdef IDEX_ILLEGAL_DETECT_EN
                chk("m_illegal", {63'd0, illegal}, {63'd0, m_w.ill});
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] i, input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] im);
        instr = i; rs1_data = r1; rs2_data = r2; imm = im; in_valid = 1'b1;
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4030D193;
    localparam logic [31:0] I_BLTU = 32'h0020E063;
    localparam logic [31:0] I_XOR  = 32'h0020C1B3;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};

    initial begin
        pc = 64'h0000_0000_8000_1000;
        repeat (3) step();
        chk("lit_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("lit_rst_a", alu_a, 64'd0);
        rst_n = 1'b1;

        // add x3,x1,x2
        drv(I_ADD, 64'd5, 64'd7, 64'd0);
        step();
        chk("lit_add_valid", {63'd0, out_valid}, 64'd1);
        chk("lit_add_op", {60'd0, alu_op}, 64'd0);
        chk("lit_add_a", alu_a, 64'd5);
        chk("lit_add_b", alu_b, 64'd7);
        in_valid = 1'b0;
        step();
        chk("lit_drain_valid", {63'd0, out_valid}, 64'd0);

        // sub then srai back-to-back
        drv(I_SUB, 64'd10, 64'd4, 64'd0);
        step();
        chk("lit_sub_op", {60'd0, alu_op}, 64'h8);
        drv(I_SRAI, -64'sd16, 64'd0, 64'd3);
        step();
        chk("lit_srai_valid", {63'd0, out_valid}, 64'd1);
        chk("lit_srai_op", {60'd0, alu_op}, 64'hD);
        chk("lit_srai_b", alu_b, 64'd3);
        in_valid = 1'b0;
        step();

        // bltu 1 vs -1
        drv(I_BLTU, 64'd1, '1, 64'd0);
        step();
        chk("lit_bltu_op", {60'd0, alu_op}, 64'h3);
        chk("lit_bltu_br", {63'd0, is_branch}, 64'd1);
        chk("lit_bltu_f3", {61'd0, br_funct3}, 64'd6);
        in_valid = 1'b0;
        step();

        // stall: held word frozen, then consumed and next loaded
        drv(I_ADD, 64'd1, 64'd2, 64'd0);
        step();
        out_ready = 1'b0;
        drv(I_XOR, 64'hF0, 64'h0F, 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lit_stall_ready", {63'd0, in_ready}, 64'd0);
            chk("lit_stall_a", alu_a, 64'd1);
            chk("lit_stall_b", alu_b, 64'd2);
        end
        out_ready = 1'b1;
        step();
        chk("lit_unstall_op", {60'd0, alu_op}, 64'h4);
        chk("lit_unstall_a", alu_a, 64'hF0);
        in_valid = 1'b0;
        step();

        // flush during stall
        drv(I_BLTU, 64'd1, 64'd9, 64'd0);
        step();
        out_ready = 1'b0;
        drv(I_ADD, 64'd77, 64'd88, 64'd0);
        flush = 1'b1;
        step();
        chk("lit_flush_valid", {63'd0, out_valid}, 64'd0);
        chk("lit_flush_br", {63'd0, is_branch}, 64'd0);
        chk("lit_flush_hold_op", {60'd0, alu_op}, 64'h3);
        chk("lit_flush_hold_a", alu_a, 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        // reset mid-stall
        drv(I_BLTU, 64'd5, 64'd6, 64'd0);
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("lit_arst_valid", {63'd0, out_valid}, 64'd0);
        chk("lit_arst_br", {63'd0, is_branch}, 64'd0);
        chk("lit_arst_a", alu_a, 64'd0);
        chk("lit_arst_op", {60'd0, alu_op}, 64'd0);
        step();
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        chk("lit_post_rst_valid", {63'd0, out_valid}, 64'd0);

        // unlisted opcode
        drv(I_BAD, 64'd9, 64'd9, 64'd9);
        step();
        chk("lit_bad_op", {60'd0, alu_op}, 64'd0);
        chk("lit_bad_a", alu_a, 64'd0);
        chk("lit_bad_b", alu_b, 64'd0);
`ifdef IDEX_ILLEGAL_DETECT_EN
        chk("lit_bad_ill", {63'd0, illegal}, 64'd1);
`endif
        in_valid = 1'b0;
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ri;
            ri = $urandom;
            ri[6:0] = opcs[$urandom_range(0, 9)];
            if (ri[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
                ri[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            if (ri[6:0] == 7'h13 && $urandom_range(0, 3) != 0)
                ri[31:26] = ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h00;
            instr     = ri;
            pc        = {$urandom, $urandom};
            rs1_data  = {$urandom, $urandom};
            rs2_data  = {$urandom, $urandom};
            imm       = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end
endmodule

// File: doc/idex_alu_ctrl.md
IDEX_ALU_CTRL -- requirements
Module: idex_alu_ctrl

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  input  1  decoded instruction presented by ID; in_ready  output  1  stage can accept.
REQ-004 SHALL have: instr  input  32  raw instruction; pc  input  64  instruction PC.
REQ-005 SHALL have: rs1_data, rs2_data, imm  input  64 each  operands and sign-extended immediate.
REQ-006 SHALL have: flush  input  1  kill held and incoming instruction.
REQ-007 SHALL have: out_valid  output  1; out_ready  input  1  EX consumes when both high.
REQ-008 SHALL have: alu_a, alu_b  output  64  registered ALU operands; alu_op  output  4  registered ALU opcode.
REQ-009 SHALL have: is_branch  output  1; br_funct3  output  3  registered, for flag-based branch resolution in EX.

Function
REQ-010 SHALL drive alu_op using the ALU encoding ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-011 R-type (0110011): alu_op = {instr[30], funct3}; a=rs1_data, b=rs2_data.
REQ-012 I-ALU (0010011): alu_op = {funct3==101 ? instr[30] : 0, funct3}; a=rs1_data, b=imm (shamt = imm[5:0]).
REQ-013 LOAD (0000011), STORE (0100011), JALR-address excluded: alu_op=ADD, a=rs1_data, b=imm.
REQ-014 BRANCH (1100011): BEQ/BNE -> SUB, BLT/BGE -> SLT, BLTU/BGEU -> SLTU; a=rs1_data, b=rs2_data; is_branch=1, br_funct3=funct3.
REQ-015 LUI: ADD, a=0, b=imm; AUIPC: ADD, a=pc, b=imm; JAL/JALR: ADD, a=pc, b=64'd4 (link value).
REQ-016 Any other opcode SHALL decode as ADD with a=0, b=0 (NOP) unless REQ-024 applies.
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-018 On clk edge with in_valid && in_ready && !flush, stage SHALL load decoded fields and set out_valid=1; latency exactly 1 cycle.
REQ-019 When out_valid && !out_ready, all registered outputs SHALL hold stable (stall).
REQ-020 When out_valid && out_ready && !(in_valid) , out_valid SHALL clear next cycle.
REQ-021 flush SHALL win over load and stall: next cycle out_valid=0, is_branch=0; data registers unchanged.
REQ-022 Back-to-back transfers SHALL sustain one instruction per cycle when out_ready held high.

Reset
REQ-023 While rst_n=0: out_valid=0, is_branch=0, br_funct3=0, alu_op=0000, alu_a=0, alu_b=0, illegal=0; reset mid-stall SHALL discard held instruction.

Configuration
REQ-024 Macro IDEX_ILLEGAL_DETECT_EN: when defined, output illegal (1 bit, registered) SHALL be 1 for unlisted opcodes and for R-type funct7 not in {0000000, 0100000} or I-type shift with instr[31:26] not in {000000, 010000}; when undefined, port absent and such instructions decode per REQ-016.

Structure
REQ-025 Shared package alu_pkg SHALL hold the 4-bit ALU opcode constants and the 7-bit RISC-V major-opcode constants, used by this block and the ALU.
REQ-026 Combinational decode SHALL be a sub-module alu_dec (instr, pc, rs1_data, rs2_data, imm -> alu_a, alu_b, alu_op, is_branch); idex_alu_ctrl owns only the handshake register.

Verification
REQ-027 add x3,x1,x2 (rs1=5, rs2=7), out_ready=1 -> next cycle out_valid=1, alu_op=0000, a=5, b=7.
REQ-028 sub then srai (imm=3, instr[30]=1) back-to-back -> alu_op 1000 then 1101 on consecutive cycles, b=3.
REQ-029 bltu rs1=1, rs2=-1 -> alu_op=0011, is_branch=1, br_funct3=110.
REQ-030 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> held word consumed, next loaded.
REQ-031 flush asserted during stall -> next cycle out_valid=0, is_branch=0; rst_n low mid-transfer -> all outputs zero.
REQ-032 With IDEX_ILLEGAL_DETECT_EN, opcode 1111111 -> illegal=1, alu_op=0000; without it -> alu_op=0000, a=0, b=0.
